// File: rtl/xbus_pkg.sv
// Shared types and constants for the AS2650 external-bus target model.
package xbus_pkg;

  typedef enum logic [1:0] {SP_MEM, SP_IOD, SP_IOC} space_e;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;

  localparam int CTRL_ARMED    = 0;
  localparam int CTRL_DONE     = 1;
  localparam int CTRL_COLL     = 2;
  localparam int CTRL_USER_LSB = 4;

  // Control space wins over IO-data, which wins over memory.
  function automatic space_e decode_space(input logic iod, input logic ioc);
    if (ioc) return SP_IOC;
    if (iod) return SP_IOD;
    return SP_MEM;
  endfunction

endpackage

// File: rtl/xbus_target_model_addr_latch.sv
// Address latch bank: one DW-wide slice per latch-enable phase, with
// transparent pass-through while the enable is high.
module xbus_addr_latch
  import xbus_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NUM_LE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        bus_out,
  input  logic [NUM_LE-1:0]    le,
  output logic [NUM_LE*DW-1:0] eff_addr
);

  logic [NUM_LE-1:0][DW-1:0] slice_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LE; i++) begin
        if (le[i]) slice_q[i] <= bus_out;
      end
    end
  end

  // An open enable forwards the bus immediately, like the original 74x373 latches.
  always_comb begin
    eff_addr = '0;
    for (int i = 0; i < NUM_LE; i++) begin
      eff_addr[i*DW +: DW] = le[i] ? bus_out : slice_q[i];
    end
  end

endmodule

// File: rtl/xbus_target_model.sv
// Bus target for the AS2650 multiplexed bus: memory, IO-data and control
// spaces, wait-state insertion on rdy, and a two-edge flag trace trigger.
module xbus_target_model
  import xbus_pkg::*;
#(
  parameter int DW          = 8,
  parameter int NUM_LE      = 2,
  parameter int MEM_AW      = 16,
  parameter int IO_AW       = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     bus_out,
  input  logic [NUM_LE-1:0] le,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic              iod,
  input  logic              ioc,
  input  logic              flag,
  output logic [DW-1:0]     bus_in,
  output logic              bus_oe,
  output logic              rdy,
  output logic              trace_armed,
  output logic              trace_done
);

  localparam int ADDR_W = NUM_LE * DW;

  logic [ADDR_W-1:0]         eff_addr;
  logic                      oe_act_q;
  logic                      we_act_q;
  logic                      flag_q;
  logic [DW-1:0]             wdata_q;
  logic [DW-1:CTRL_USER_LSB] ctrl_user_q;
  logic                      coll_q;
  rd_state_e                 state_q;
  logic [3:0]                wcnt_q;

  logic [DW-1:0] mem      [2**MEM_AW];
  logic [DW-1:0] iod_regs [2**IO_AW];

  space_e        space;
  logic          oe_fall;
  logic          we_rise;
  logic          collision;
  logic [DW-1:0] ctrl_rd;
  logic [DW-1:0] rd_data;

  xbus_addr_latch #(
    .DW     (DW),
    .NUM_LE (NUM_LE)
  ) u_addr_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_out  (bus_out),
    .le       (le),
    .eff_addr (eff_addr)
  );

  // Edge registers hold the active-low strobes inverted so a cleared
  // register after reset can never fake a write commit.
  always_comb begin
    space     = decode_space(iod, ioc);
    oe_fall   = ~oe_n & ~oe_act_q;
    we_rise   = we_n & we_act_q;
    collision = ~oe_n & ~we_n;

    ctrl_rd                       = '0;
    ctrl_rd[DW-1:CTRL_USER_LSB]   = ctrl_user_q;
    ctrl_rd[CTRL_COLL]            = coll_q;
    ctrl_rd[CTRL_DONE]            = trace_done;
    ctrl_rd[CTRL_ARMED]           = trace_armed;

    case (space)
      SP_IOC:  rd_data = ctrl_rd;
      SP_IOD:  rd_data = iod_regs[eff_addr[IO_AW-1:0]];
      default: rd_data = mem[eff_addr[MEM_AW-1:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_act_q    <= 1'b0;
      we_act_q    <= 1'b0;
      flag_q      <= 1'b0;
      wdata_q     <= '0;
      ctrl_user_q <= '0;
      coll_q      <= 1'b0;
      trace_armed <= 1'b0;
      trace_done  <= 1'b0;
    end else begin
      oe_act_q <= ~oe_n;
      we_act_q <= ~we_n;
      flag_q   <= flag;
      if (!we_n) wdata_q <= bus_out;
      if (we_rise && space == SP_IOC) ctrl_user_q <= wdata_q[DW-1:CTRL_USER_LSB];
      if (collision) coll_q <= 1'b1;
      if (flag && !flag_q) begin
        if (!trace_armed) trace_armed <= 1'b1;
        else              trace_done  <= 1'b1;
      end
    end
  end

  // Read FSM; a collision or released oe_n always wins and blanks the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      wcnt_q  <= '0;
      bus_in  <= '0;
      bus_oe  <= 1'b0;
      rdy     <= 1'b0;
    end else if (oe_n || collision) begin
      state_q <= RD_IDLE;
      bus_in  <= '0;
      bus_oe  <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (oe_fall) begin
            bus_oe <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= RD_DATA;
              rdy     <= 1'b1;
              bus_in  <= rd_data;
            end else begin
              state_q <= RD_WAIT;
              wcnt_q  <= 4'(WAIT_STATES - 1);
            end
          end
        end
        RD_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q <= RD_DATA;
            rdy     <= 1'b1;
            bus_in  <= rd_data;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        RD_DATA: begin
          bus_in <= rd_data;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  // Storage arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (we_rise && space == SP_MEM) mem[eff_addr[MEM_AW-1:0]] <= wdata_q;
    if (we_rise && space == SP_IOD) iod_regs[eff_addr[IO_AW-1:0]] <= wdata_q;
  end

endmodule

// File: doc/xbus_target_model.md
Name: xbus_target_model

Overview:
- Synthesizable, parametrised target for the AS2650 multiplexed external bus.
- Replaces the hand-written address latch, RAM and trace-flag logic in the emulation bench.
- Captures address phases from the latch-enable strobes, serves memory, IO-data and IO-control spaces, and inserts configurable wait states on a ready line.
- Tracks the CPU's flag output as a two-edge trace arm/done trigger.

Parameters:
- DW, 8, width of the multiplexed data/address bus.
- NUM_LE, 2, number of address latch phases; ADDR_W = NUM_LE*DW.
- MEM_AW, 16, memory index width (depth 2^MEM_AW); must be <= ADDR_W, upper address bits alias.
- IO_AW, 4, IO-data register file index width (2^IO_AW registers of DW bits).
- WAIT_STATES, 1, cycles of rdy=0 before read data is valid (0..15).

Ports:
- clk  in  1  bus/system clock.
- rst_n  in  1  asynchronous active-low reset.
- bus_out  in  DW  value driven by the CPU (address phases and write data).
- le  in  NUM_LE  latch enables; le[i] captures address slice i.
- oe_n  in  1  read strobe, active low.
- we_n  in  1  write strobe, active low.
- iod  in  1  IO-data space select.
- ioc  in  1  IO-control space select.
- flag  in  1  CPU flag output, used as trace trigger.
- bus_in  out  DW  read data to the CPU.
- bus_oe  out  1  target is driving bus_in.
- rdy  out  1  read data valid / cycle may complete.
- trace_armed  out  1  first flag rising edge seen.
- trace_done  out  1  second flag rising edge seen.

Behaviour:
- Reset (async, rst_n=0): bus_in=0, bus_oe=0, rdy=0, trace_armed=0, trace_done=0. Address latch, edge registers, wait counter and ctrl register are cleared. Memory and IO-data arrays are not reset and hold their contents.
- Inputs are sampled on posedge clk. Edges are detected against the previous-cycle registered copy.
- Address latch (per slice i):
  - While le[i]=1, the slice loads bus_out every cycle.
  - When le[i]=0, the slice holds.
  - Effective address eff_addr: slice i = le[i] ? bus_out : latched slice (transparent-latch emulation).
- Space decode by priority: ioc=1 selects the control register; else iod=1 selects IO-data[eff_addr[IO_AW-1:0]]; else memory[eff_addr[MEM_AW-1:0]].
- Read FSM states: IDLE, WAIT, DATA.
  - IDLE to WAIT on an oe_n falling edge with we_n=1 (cycle N).
  - bus_oe=1 from N+1. rdy=0 and bus_in=0 during WAIT.
  - At cycle N+1+WAIT_STATES: rdy=1 and bus_in = selected data registered from eff_addr at that edge (state DATA). WAIT_STATES=0 gives rdy=1 at N+1.
  - DATA re-reads every cycle, so data tracks address changes.
  - Any state returns to IDLE when oe_n=1: bus_oe=0, rdy=0, bus_in=0 the next cycle.
- Write:
  - While we_n=0, wdata <= bus_out each cycle.
  - On a we_n rising edge, wdata is committed to the selected space at eff_addr. The commit is a single-cycle event.
  - Writes to ioc space update ctrl[DW-1:4] only; the low bits are status.
- Collision (oe_n=0 and we_n=0 in the same cycle):
  - The read is suppressed: FSM forced to IDLE, bus_oe=0, rdy=0.
  - The write still commits.
  - Sticky status bit ctrl[2]=1 until reset.
- Control register read value: {ctrl[DW-1:4], 1'b0, collision, trace_done, trace_armed}.
- Trace:
  - First flag rising edge: trace_armed=1.
  - Next rising edge while armed: trace_done=1.
  - Both are sticky. Further edges are ignored.
- Reset mid-read drops bus_oe/rdy immediately (asynchronously). No partial write commits after reset.

Decomposition:
- Shared package xbus_pkg holds:
  - space enum SP_MEM/SP_IOD/SP_IOC;
  - read FSM state enum;
  - ctrl status bit indices CTRL_ARMED=0, CTRL_DONE=1, CTRL_COLL=2, CTRL_USER_LSB=4.
- Sub-module xbus_addr_latch (params DW, NUM_LE): holds the latch bank and produces eff_addr.

Test Plan (DW=8, NUM_LE=2, MEM_AW=16, WAIT_STATES=1):
- Memory write: le[0] pulse with bus 0x34, le[1] pulse with 0x12, bus_out=0xA5, we_n low 2 cycles then high -> mem[0x1234]=0xA5.
- Memory read: same address, oe_n falls at cycle N -> bus_oe=1 and rdy=0 at N+1; rdy=1 and bus_in=0xA5 at N+2; oe_n high -> bus_oe=0, bus_in=0 next cycle.
- Transparent latch: during a read, raise le[1] with bus_out=0x56 -> data from mem[0x5634] appears the following cycle.
- IO isolation: iod=1, write 0x3C to address 0x0003 -> IO read returns 0x3C; memory read of 0x0003 returns its prior value; ioc=1 write 0xF0 -> ctrl read 0xF0 (status bits 0).
- Trace and collision:
  - Flag rising edges at cycles 10 and 20 -> trace_armed=1 from 11, trace_done=1 from 21.
  - oe_n=we_n=0 together -> bus_oe stays 0; ctrl read returns bit2=1.
- Async reset: assert rst_n=0 in the WAIT state -> bus_oe, rdy, trace_armed and trace_done all 0 without a clock edge; mem[0x1234] still reads 0xA5 after release.
